sqrt_seq: RTL and testbench



---
 rtl/sqrt_seq.sv | 173 +++++++++++++++++
 tb/tb_sqrt_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_seq.sv
// -----------------------------------------------------------------------------
// sqrt_seq : multi-cycle integer square root, floor(sqrt(radicand)).
//
// Restoring digit-by-digit algorithm: one root bit is resolved per clock.
// After the last iteration a one-cycle wrap-up stage keeps busy high.
// In the following cycle the results are registered and done pulses.
//
// Parameters:
//   WIDTH     radicand width in bits (even, >= 2). Root width RW = WIDTH/2.
//
// Ports:
//   clk        single clock, rising-edge active
//   reset      asynchronous, active-high reset
//   start      request pulse, sampled only while idle
//   radicand   operand, captured on the accepting edge
//   busy       high from the accepting edge until done is asserted
//   done       one-cycle pulse, results valid from this cycle on
//   root       floor(sqrt(radicand)), held until the next done
//   exact      radicand is a perfect square (remainder == 0)
//   remainder  radicand - root*root (only with SQRT_REM_OUT_EN)
//
// Optional feature macro: SQRT_REM_OUT_EN adds the remainder output port.
// -----------------------------------------------------------------------------
module sqrt_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     radicand,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH/2-1:0]   root,
  output logic                 exact
`ifdef SQRT_REM_OUT_EN
  ,
  output logic [WIDTH/2:0]     remainder
`endif
);

  localparam int RW = WIDTH / 2;
  localparam int CW = (RW > 1) ? $clog2(RW) : 1;

  // S_FINISH is the extra busy cycle between the last iteration and done.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_next_s;

  logic [WIDTH-1:0] op_r;
  logic [RW+1:0]    rem_r;
  logic [RW-1:0]    root_p_r;
  logic [CW-1:0]    cnt_r;

  logic [RW+1:0]    rem_shift_s;
  logic [RW+1:0]    trial_s;
  logic [RW+1:0]    rem_step_s;
  logic [RW:0]      root_ext_s;
  logic [RW-1:0]    root_step_s;

  // One restoring iteration: bring down two operand bits, try subtracting 4r+1.
  always_comb begin
    // The top bit of rem_r is always zero between iterations.
    // It can be dropped before the shift.
    rem_shift_s = {rem_r[RW-1:0], op_r[WIDTH-1 -: 2]};
    trial_s     = {root_p_r, 2'b01};
    rem_step_s  = rem_shift_s;
    root_ext_s  = {root_p_r, 1'b0};
    if (rem_shift_s >= trial_s) begin
      rem_step_s = rem_shift_s - trial_s;
      root_ext_s = {root_p_r, 1'b1};
    end else begin
      rem_step_s = rem_shift_s;
      root_ext_s = {root_p_r, 1'b0};
    end
    root_step_s = root_ext_s[RW-1:0];
  end

  // Next-state logic of the control FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_next_s = S_CALC;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_next_s = S_FINISH;
        end else begin
          state_next_s = S_CALC;
        end
      end
      S_FINISH: state_next_s = S_DONE;
      S_DONE:   state_next_s = S_IDLE;
      default:  state_next_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: operand shift register, partial remainder/root, iteration count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r     <= {WIDTH{1'b0}};
      rem_r    <= {(RW+2){1'b0}};
      root_p_r <= {RW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            op_r     <= radicand;
            rem_r    <= {(RW+2){1'b0}};
            root_p_r <= {RW{1'b0}};
            cnt_r    <= CW'(RW - 1);
          end
        end
        S_CALC: begin
          op_r     <= op_r << 2;
          rem_r    <= rem_step_s;
          root_p_r <= root_step_s;
          if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        default: begin
          op_r <= op_r;
        end
      endcase
    end
  end

  // Registered handshake and result outputs; results only change entering DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      root  <= {RW{1'b0}};
      exact <= 1'b0;
`ifdef SQRT_REM_OUT_EN
      remainder <= {(RW+1){1'b0}};
`endif
    end else begin
      busy <= (state_next_s == S_CALC) || (state_next_s == S_FINISH);
      done <= (state_next_s == S_DONE);
      if (state_r == S_FINISH) begin
        root  <= root_p_r;
        exact <= (rem_r == {(RW+2){1'b0}});
`ifdef SQRT_REM_OUT_EN
        // Final remainder <= 2*root, so the top bit of rem_r is zero.
        remainder <= rem_r[RW:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_sqrt_seq.sv
// -----------------------------------------------------------------------------
// Testbench for sqrt_seq: WIDTH=8 and WIDTH=16 instances.
// Covers table vectors, a busy-time request, a mid-operation reset,
// latency checks and an exhaustive WIDTH=8 sweep with start held high.
// -----------------------------------------------------------------------------
module tb_sqrt_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start8;
  logic [7:0] rad8;
  logic       busy8, done8, exact8;
  logic [3:0] root8;
`ifdef SQRT_REM_OUT_EN
  logic [4:0] rem8;
`endif

  logic        start16;
  logic [15:0] rad16;
  logic        busy16, done16, exact16;
  logic [7:0]  root16;
`ifdef SQRT_REM_OUT_EN
  logic [8:0]  rem16;
`endif

  sqrt_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .radicand(rad8),
    .busy(busy8), .done(done8), .root(root8), .exact(exact8)
`ifdef SQRT_REM_OUT_EN
    , .remainder(rem8)
`endif
  );

  sqrt_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .radicand(rad16),
    .busy(busy16), .done(done16), .root(root16), .exact(exact16)
`ifdef SQRT_REM_OUT_EN
    , .remainder(rem16)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] rad;
    logic [3:0] root;
    logic       exact;
    logic [4:0] rem;
  } vec_t;

  vec_t vecs[10];
  vec_t sb[$];
  vec_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Scoreboard: every done pulse of the 8-bit unit pops one expectation.
  always @(negedge clk) begin
    if (!reset && done8) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("root", root8, mon_e.root);
        check("exact", exact8, mon_e.exact);
`ifdef SQRT_REM_OUT_EN
        check("remainder", rem8, mon_e.rem);
        check("recon", root8 * root8 + rem8, mon_e.rad);
`endif
      end
    end
  end

  task automatic wait_idle8();
    int n = 0;
    @(negedge clk);
    while ((busy8 || done8) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (busy8 || done8) check("idle_timeout8", 0, 1);
  endtask

  task automatic issue8(input logic [7:0] v, input logic [3:0] r,
                        input logic e, input logic [4:0] m);
    vec_t x;
    wait_idle8();
    start8 = 1'b1;
    rad8   = v;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    check("accept8", busy8, 1);
    x.rad = v; x.root = r; x.exact = e; x.rem = m;
    sb.push_back(x);
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done8) check("done_timeout8", 0, 1);
  endtask

  task automatic run16(input logic [15:0] v, input logic [7:0] r,
                       input logic e, input logic [8:0] m);
    int n = 0;
    @(negedge clk);
    start16 = 1'b1;
    rad16   = v;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    while (!done16 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency16", n, 10);
    check("root16", root16, r);
    check("exact16", exact16, e);
`ifdef SQRT_REM_OUT_EN
    check("remainder16", rem16, m);
`else
    if (m == 9'd0) check("exact16_vs_rem", exact16, 1);
`endif
  endtask

  initial begin
    vec_t x;
    vecs[0] = '{8'd143, 4'd11, 1'b0, 5'd22};
    vecs[1] = '{8'd255, 4'd15, 1'b0, 5'd30};
    vecs[2] = '{8'd0,   4'd0,  1'b1, 5'd0};
    vecs[3] = '{8'd1,   4'd1,  1'b1, 5'd0};
    vecs[4] = '{8'd2,   4'd1,  1'b0, 5'd1};
    vecs[5] = '{8'd63,  4'd7,  1'b0, 5'd14};
    vecs[6] = '{8'd64,  4'd8,  1'b1, 5'd0};
    vecs[7] = '{8'd225, 4'd15, 1'b1, 5'd0};
    vecs[8] = '{8'd99,  4'd9,  1'b0, 5'd18};
    vecs[9] = '{8'd144, 4'd12, 1'b1, 5'd0};

    reset = 1'b1; start8 = 1'b0; rad8 = 8'd0; start16 = 1'b0; rad16 = 16'd0;
    #12;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_root", root8, 0);
    check("rst_exact", exact8, 0);
    @(negedge clk);
    reset = 1'b0;

    // 144: busy for 5 cycles, done in the 6th, then back to idle.
    issue8(8'd144, 4'd12, 1'b1, 5'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("lat_busy", busy8, 1);
      check("lat_nodone", done8, 0);
    end
    @(negedge clk);
    check("lat_done", done8, 1);
    check("lat_busy_low", busy8, 0);
    @(negedge clk);
    check("done_pulse", done8, 0);

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      issue8(vecs[i].rad, vecs[i].root, vecs[i].exact, vecs[i].rem);
      wait_done8();
    end

    // Request while busy is ignored.
    issue8(8'd49, 4'd7, 1'b1, 5'd0);
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1;
    rad8   = 8'd200;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    check("still_busy", busy8, 1);
    wait_done8();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_root", root8, 7);
      check("hold_exact", exact8, 1);
      check("hold_idle", busy8, 0);
    end

    // Reset during the third CALC cycle aborts the operation.
    issue8(8'd100, 4'd10, 1'b1, 5'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_root", root8, 0);
    check("abort_exact", exact8, 0);
    check("abort_done", done8, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    issue8(8'd81, 4'd9, 1'b1, 5'd0);
    wait_done8();

    // 16-bit instance.
    run16(16'd65535, 8'd255, 1'b0, 9'd510);
    run16(16'd65025, 8'd255, 1'b1, 9'd0);

    // Exhaustive sweep with start held high: one idle cycle between ops.
    wait_idle8();
    for (int v = 0; v < 256; v++) begin
      rad8   = v[7:0];
      start8 = 1'b1;
      @(posedge clk);
      #1;
      check("sweep_accept", busy8, 1);
      x.rad   = v[7:0];
      x.root  = 4'(isqrt(v));
      x.exact = (isqrt(v) * isqrt(v) == v);
      x.rem   = 5'(v - isqrt(v) * isqrt(v));
      sb.push_back(x);
      rad8 = ~v[7:0];
      wait_done8();
      @(negedge clk);
      check("idle_gap", {busy8, done8}, 0);
    end
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
